// File: rtl/deser_frame_sched_pkg.sv
// Shared constants, state encodings and the saturating drop-count helper for deser_frame_sched.
package deser_frame_sched_pkg;

  localparam int DESER_FRAME_WORDS = 4;
  localparam int DROP_CNT_WIDTH    = 8;

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_e;
  typedef enum logic {OUT_IDLE = 1'b0, OUT_HOLD = 1'b1} out_state_e;

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_add_drop(
    input logic [DROP_CNT_WIDTH-1:0] cnt,
    input logic [1:0]                inc
  );
    logic [DROP_CNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + {{(DROP_CNT_WIDTH-1){1'b0}}, inc};
    return sum[DROP_CNT_WIDTH] ? {DROP_CNT_WIDTH{1'b1}} : sum[DROP_CNT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/deser_frame_sched_frame_slot.sv
// One-frame capture slot: done edge detect, frame store, overrun detect and the optional
// checksum filter selected by DESER_FRAME_CHECK_EN.
module frame_slot
  import deser_frame_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               done_i,
  input  logic [DESER_FRAME_WORDS*WIDTH-1:0] frame_i,
  input  logic                               grant_i,
`ifdef DESER_FRAME_CHECK_EN
  output logic                               drop_o,
`endif
  output logic                               full_o,
  output logic                               ovf_set_o,
  output logic [DESER_FRAME_WORDS*WIDTH-1:0] frame_o
);

  logic                               done_q;
  slot_state_e                        slot_q, slot_d;
  logic [DESER_FRAME_WORDS*WIDTH-1:0] data_q, data_d;
  logic                               start, chk_ok, accept;

  assign start = done_i & ~done_q;

`ifdef DESER_FRAME_CHECK_EN
  assign chk_ok = frame_i[WIDTH-1:0] == (frame_i[4*WIDTH-1:3*WIDTH] +
                                         frame_i[3*WIDTH-1:2*WIDTH] +
                                         frame_i[2*WIDTH-1:WIDTH]);
  assign drop_o = start & ~chk_ok;
`else
  assign chk_ok = 1'b1;
`endif

  // A slot being granted this cycle is free again, so a new frame may refill it.
  assign accept    = start & chk_ok & ((slot_q == SLOT_EMPTY) | grant_i);
  assign ovf_set_o = start & chk_ok & (slot_q == SLOT_FULL) & ~grant_i;
  assign full_o    = (slot_q == SLOT_FULL);
  assign frame_o   = data_q;

  always_comb begin
    slot_d = slot_q;
    data_d = data_q;
    if (accept) begin
      slot_d = SLOT_FULL;
      data_d = frame_i;
    end else if (grant_i) begin
      slot_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      slot_q <= SLOT_EMPTY;
      data_q <= '0;
    end else begin
      done_q <= done_i;
      slot_q <= slot_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/deser_frame_sched.sv
// Two-channel frame scheduler: round-robin arbiter, registered valid/ready output, sticky
// overrun flags and (with DESER_FRAME_CHECK_EN defined) a saturating checksum-drop counter.
module deser_frame_sched
  import deser_frame_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               done0,
  input  logic                               done1,
  input  logic [DESER_FRAME_WORDS*WIDTH-1:0] frame0,
  input  logic [DESER_FRAME_WORDS*WIDTH-1:0] frame1,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DESER_FRAME_WORDS*WIDTH-1:0] out_frame,
  output logic                               out_chan,
  output logic [1:0]                         ovf,
  input  logic                               clr_ovf,
  output logic [DROP_CNT_WIDTH-1:0]          drop_cnt
);

  logic                               full0, full1, grant0, grant1, out_free;
  logic                               ovf_set0, ovf_set1;
  logic [DESER_FRAME_WORDS*WIDTH-1:0] slot_frame0, slot_frame1;
  out_state_e                         out_state_q;
  logic [DESER_FRAME_WORDS*WIDTH-1:0] out_frame_q;
  logic                               out_chan_q, last_q;
  logic [1:0]                         ovf_q;
`ifdef DESER_FRAME_CHECK_EN
  logic                               drop0, drop1;
`endif

  frame_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk(clk), .rst_n(rst_n), .done_i(done0), .frame_i(frame0), .grant_i(grant0),
`ifdef DESER_FRAME_CHECK_EN
    .drop_o(drop0),
`endif
    .full_o(full0), .ovf_set_o(ovf_set0), .frame_o(slot_frame0)
  );

  frame_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk(clk), .rst_n(rst_n), .done_i(done1), .frame_i(frame1), .grant_i(grant1),
`ifdef DESER_FRAME_CHECK_EN
    .drop_o(drop1),
`endif
    .full_o(full1), .ovf_set_o(ovf_set1), .frame_o(slot_frame1)
  );

  // On a tie the channel that did not win last time goes next.
  assign out_free = (out_state_q == OUT_IDLE) | out_ready;
  assign grant0   = out_free & full0 & (~full1 | last_q);
  assign grant1   = out_free & full1 & (~full0 | ~last_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_state_q <= OUT_IDLE;
      out_frame_q <= '0;
      out_chan_q  <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      unique case (out_state_q)
        OUT_IDLE: begin
          if (grant0 | grant1) begin
            out_state_q <= OUT_HOLD;
            out_frame_q <= grant1 ? slot_frame1 : slot_frame0;
            out_chan_q  <= grant1;
            last_q      <= grant1;
          end
        end
        OUT_HOLD: begin
          if (grant0 | grant1) begin
            out_frame_q <= grant1 ? slot_frame1 : slot_frame0;
            out_chan_q  <= grant1;
            last_q      <= grant1;
          end else if (out_ready) begin
            out_state_q <= OUT_IDLE;
          end
        end
        default: out_state_q <= OUT_IDLE;
      endcase
    end
  end

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 2'b00;
    else        ovf_q <= {ovf_set1, ovf_set0} | (clr_ovf ? 2'b00 : ovf_q);
  end

`ifdef DESER_FRAME_CHECK_EN
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= sat_add_drop(drop_cnt_q, {1'b0, drop0} + {1'b0, drop1});
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  assign out_valid = (out_state_q == OUT_HOLD);
  assign out_frame = out_frame_q;
  assign out_chan  = out_chan_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_deser_frame_sched.sv
// Self-checking bench for deser_frame_sched: directed plan scenarios plus random traffic
// compared every cycle against a frame-level model; honours DESER_FRAME_CHECK_EN.
module tb_deser_frame_sched;

  localparam int WIDTH = 8;
  localparam int FW    = 4 * WIDTH;

  logic          clk = 1'b0;
  logic          rst_n, done0, done1, out_ready, clr_ovf;
  logic [FW-1:0] frame0, frame1, out_frame;
  logic          out_valid, out_chan;
  logic [1:0]    ovf;
  logic [7:0]    drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  deser_frame_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .done0(done0), .done1(done1),
    .frame0(frame0), .frame1(frame1), .out_valid(out_valid), .out_ready(out_ready),
    .out_frame(out_frame), .out_chan(out_chan), .ovf(ovf), .clr_ovf(clr_ovf),
    .drop_cnt(drop_cnt)
  );

  function automatic logic [FW-1:0] mkFrame(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c);
    logic [7:0] s;
    s = a + b + c;
    return {a, b, c, s};
  endfunction

  function automatic bit sumOk(input logic [FW-1:0] f);
`ifdef DESER_FRAME_CHECK_EN
    int s;
    s = int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return (s % 256) == int'(f[7:0]);
`else
    return f === f;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: one buffered frame per channel, an output holding register,
  // and a "who went last" bit for tie-breaking; advanced once per rising edge.
  bit            mSeen[2];
  bit            mHas[2];
  logic [FW-1:0] mBuf[2];
  bit            mLast, mValid, mChan, modelLive = 0;
  logic [FW-1:0] mFrame;
  bit   [1:0]    mOvf;
  int            mDrop, win;
  bit            dn[2];
  logic [FW-1:0] fin[2];

  always @(posedge clk) begin
    dn[0] = done0;  dn[1] = done1;
    fin[0] = frame0; fin[1] = frame1;
    if (!rst_n) begin
      mSeen = '{0, 0}; mHas = '{0, 0};
      mLast = 1; mValid = 0; mChan = 0; mFrame = '0; mOvf = 0; mDrop = 0;
    end else begin
      win = -1;
      if (!mValid || out_ready) begin
        if (mHas[0] && mHas[1]) win = mLast ? 0 : 1;
        else if (mHas[0])       win = 0;
        else if (mHas[1])       win = 1;
      end
      if (win >= 0) begin
        mValid = 1; mFrame = mBuf[win]; mChan = win[0]; mLast = win[0]; mHas[win] = 0;
      end else if (out_ready) begin
        mValid = 0;
      end
      if (clr_ovf) mOvf = 0;
      for (int ch = 0; ch < 2; ch++) begin
        if (dn[ch] && !mSeen[ch]) begin
          if (!sumOk(fin[ch]))  mDrop = (mDrop + 1 > 255) ? 255 : mDrop + 1;
          else if (!mHas[ch]) begin mHas[ch] = 1; mBuf[ch] = fin[ch]; end
          else                  mOvf[ch] = 1;
        end
        mSeen[ch] = dn[ch];
      end
    end
    modelLive = 1;
  end

  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("model out_valid", 64'(out_valid), 64'(mValid));
      if (mValid) begin
        checkOutput("model out_frame", 64'(out_frame), 64'(mFrame));
        checkOutput("model out_chan", 64'(out_chan), 64'(mChan));
      end
      checkOutput("model ovf", 64'(ovf), 64'(mOvf));
      checkOutput("model drop_cnt", 64'(drop_cnt), 64'(mDrop));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input int ch, input logic [FW-1:0] f);
    if (ch == 0) begin done0 = 1'b1; frame0 = f; end
    else         begin done1 = 1'b1; frame1 = f; end
    tick(1);
    if (ch == 0) done0 = 1'b0; else done1 = 1'b0;
    tick(1);
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 2) == 0) done0 = ~done0;
      if ($urandom_range(0, 2) == 0) done1 = ~done1;
      frame0 = mkFrame(8'($urandom), 8'($urandom), 8'($urandom));
      frame1 = mkFrame(8'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) frame0[7:0] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) frame1[7:0] = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 19) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    rst_n = 1'b1; clr_ovf = 1'b0; done0 = 1'b0; done1 = 1'b0;
  endtask

  logic [FW-1:0] fa, fb, fc, fd, fe, badF;

  initial begin
    rst_n = 1'b0; done0 = 1'b0; done1 = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    frame0 = '0; frame1 = '0;
    tick(2);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out_frame", 64'(out_frame), 64'd0);
    checkOutput("reset out_chan", 64'(out_chan), 64'd0);
    checkOutput("reset ovf", 64'(ovf), 64'd0);
    checkOutput("reset drop_cnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;

    // Single frame: valid exactly two edges after done rises, for one cycle.
    out_ready = 1'b1;
    done0 = 1'b1; frame0 = 32'h01020306;
    tick(1);
    done0 = 1'b0;
    checkOutput("single n+1 valid", 64'(out_valid), 64'd0);
    tick(1);
    checkOutput("single n+2 valid", 64'(out_valid), 64'd1);
    checkOutput("single frame", 64'(out_frame), 64'h01020306);
    checkOutput("single chan", 64'(out_chan), 64'd0);
    tick(1);
    checkOutput("single n+3 valid", 64'(out_valid), 64'd0);

    // Simultaneous arrival after a fresh reset: channel 0 first, both times.
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    fa = mkFrame(8'h11, 8'h22, 8'h33); fb = mkFrame(8'h44, 8'h55, 8'h66);
    for (int rep = 0; rep < 2; rep++) begin
      done0 = 1'b1; frame0 = fa; done1 = 1'b1; frame1 = fb;
      tick(1);
      done0 = 1'b0; done1 = 1'b0;
      tick(1);
      checkOutput("simul first chan", 64'(out_chan), 64'd0);
      checkOutput("simul first frame", 64'(out_frame), 64'(fa));
      tick(1);
      checkOutput("simul second chan", 64'(out_chan), 64'd1);
      checkOutput("simul second frame", 64'(out_frame), 64'(fb));
      tick(1);
      checkOutput("simul drained", 64'(out_valid), 64'd0);
    end

    // Back-pressure and overrun: C arrives while B still waits.
    out_ready = 1'b0;
    fa = mkFrame(8'h01, 8'h01, 8'h01); fb = mkFrame(8'h02, 8'h02, 8'h02);
    fc = mkFrame(8'h03, 8'h03, 8'h03);
    pulse(0, fa); pulse(0, fb); pulse(0, fc);
    checkOutput("bp held frame", 64'(out_frame), 64'(fa));
    checkOutput("bp held valid", 64'(out_valid), 64'd1);
    checkOutput("bp ovf", 64'(ovf), 64'b01);
    out_ready = 1'b1;
    tick(1);
    checkOutput("bp B follows", 64'(out_frame), 64'(fb));
    tick(1);
    checkOutput("bp C never out", 64'(out_valid), 64'd0);
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    checkOutput("bp ovf cleared", 64'(ovf), 64'b00);

    // Refill on drain: channel 1 captures in the same cycle its slot is granted.
    out_ready = 1'b0;
    fc = mkFrame(8'h0a, 8'h0b, 8'h0c); fd = mkFrame(8'h21, 8'h43, 8'h65);
    fe = mkFrame(8'h87, 8'ha9, 8'hcb);
    pulse(0, fc); pulse(1, fd);
    out_ready = 1'b1; done1 = 1'b1; frame1 = fe;
    tick(1);
    done1 = 1'b0;
    checkOutput("refill D out", 64'(out_frame), 64'(fd));
    checkOutput("refill D chan", 64'(out_chan), 64'd1);
    tick(1);
    checkOutput("refill E out", 64'(out_frame), 64'(fe));
    checkOutput("refill ovf1", 64'(ovf[1]), 64'd0);
    tick(1);

    // Checksum: a bad frame and then 300 more.
    badF = 32'h10203000;
    pulse(0, badF);
`ifdef DESER_FRAME_CHECK_EN
    checkOutput("chk dropped valid", 64'(out_valid), 64'd0);
    checkOutput("chk drop_cnt one", 64'(drop_cnt), 64'd1);
`else
    checkOutput("chk forwarded valid", 64'(out_valid), 64'd1);
    checkOutput("chk forwarded frame", 64'(out_frame), 64'(badF));
    checkOutput("chk drop_cnt zero", 64'(drop_cnt), 64'd0);
`endif
    tick(1);
    for (int i = 0; i < 150; i++) begin
      done0 = 1'b1; done1 = 1'b1; frame0 = badF; frame1 = badF;
      tick(1);
      done0 = 1'b0; done1 = 1'b0;
      tick(1);
    end
`ifdef DESER_FRAME_CHECK_EN
    checkOutput("chk drop saturated", 64'(drop_cnt), 64'd255);
`else
    checkOutput("chk drop tied", 64'(drop_cnt), 64'd0);
`endif
    tick(4);

    // Reset mid-operation with done0 held high through it.
    out_ready = 1'b0;
    pulse(0, mkFrame(8'h05, 8'h05, 8'h05));
    pulse(0, mkFrame(8'h06, 8'h06, 8'h06));
    pulse(1, mkFrame(8'h07, 8'h07, 8'h07));
    checkOutput("mid busy valid", 64'(out_valid), 64'd1);
    fa = mkFrame(8'h09, 8'h08, 8'h07);
    rst_n = 1'b0; done0 = 1'b1; frame0 = fa;
    tick(1);
    checkOutput("mid rst valid", 64'(out_valid), 64'd0);
    checkOutput("mid rst frame", 64'(out_frame), 64'd0);
    checkOutput("mid rst chan", 64'(out_chan), 64'd0);
    checkOutput("mid rst ovf", 64'(ovf), 64'd0);
    checkOutput("mid rst drop", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    tick(1);
    checkOutput("mid capture valid", 64'(out_valid), 64'd0);
    tick(1);
    checkOutput("mid held-done valid", 64'(out_valid), 64'd1);
    checkOutput("mid held-done frame", 64'(out_frame), 64'(fa));
    tick(1);
    checkOutput("mid single capture", 64'(out_valid), 64'd0);
    done0 = 1'b0;
    tick(1);

    applyStimulus(3000);
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deser_frame_sched.md
# deser_frame_sched

Two-channel frame scheduler placed downstream of two `deserializer` instances. It captures each completed 4-word frame when the channel's `done` rises. It buffers one frame per channel and shares a single valid/ready output port between the channels using round-robin arbitration. It flags overruns and, when configured, drops frames that fail a checksum.

## Interface
- `WIDTH`, default 8: word width; it matches the `deserializer` `width`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset; synchronous, active-low.
- `done0`, `done1` input 1: channel done level, taken directly from the deserializer.
- `frame0`, `frame1` input 4*WIDTH: the channel words packed as {out3, out2, out1, out0}.
- `out_valid` output 1: the output frame is present.
- `out_ready` input 1: the consumer accepts the frame.
- `out_frame` output 4*WIDTH: the granted frame.
- `out_chan` output 1: the source channel of `out_frame`.
- `ovf` output 2: sticky overrun flag per channel.
- `clr_ovf` input 1: clears `ovf`.
- `drop_cnt` output 8: count of checksum-failed frames.

## Operation
- **Capture**
  - Per channel, a `done_q` register is kept, and `start = done & ~done_q`.
  - On `start`, `frame` is sampled in that same cycle.
  - The frame is written into the channel slot, and `slot_full` is set.
- **Slot states:** EMPTY goes to FULL on capture. FULL goes to EMPTY when the slot is granted.
- **Overrun**
  - If `start` occurs while the slot is FULL and the slot is not granted that cycle, the new frame is discarded. The stored frame is kept and `ovf[ch]` is set.
  - If `start` occurs in the same cycle the slot is granted, the new frame is captured and no overrun is flagged.
- **Output register states**
  - IDLE (`out_valid` = 0) goes to HOLD when any slot is FULL.
  - In HOLD, the state stays HOLD if `out_ready` = 1 and another slot is FULL; in that case the next frame is loaded back-to-back.
  - HOLD goes to IDLE if `out_ready` = 1 and no slot is FULL.
  - HOLD stays HOLD with the outputs frozen if `out_ready` = 0.
- **Grant**
  - A grant occurs when `(~out_valid | out_ready)` holds and at least one slot is FULL.
  - With one slot FULL, that slot wins.
  - With both slots FULL, the channel opposite to `last` wins.
  - `last` is updated to the granted channel.
- **Output stability:** `out_frame` and `out_chan` do not change while `out_valid & ~out_ready`.
- **ovf clear priority:** `clr_ovf` clears both `ovf` bits. A set event in the same cycle wins, so the flag stays 1.
- **Reset:** `rst_n` = 0 at an edge has these effects, and applies mid-frame as well:
  - `out_valid` = 0, `out_frame` = 0, `out_chan` = 0.
  - Both slots EMPTY, `done_q` = 0, `ovf` = 0, `drop_cnt` = 0.
  - `last` = 1, so channel 0 wins the first tie.
  - A `done` level still high after reset counts as a rising edge (`done_q` = 0), so that frame is captured.

## Timing
- **Capture-to-output latency:**
  - `done` rises in cycle n, so `start` is in cycle n.
  - The slot is FULL from cycle n+1.
  - `out_valid` is 1 from cycle n+2 if the output is free.
- **Throughput:** one frame per cycle on the output while both slots keep refilling.
- **Handshake:** the transfer occurs on an edge where `out_valid & out_ready`. `out_ready` may be held high permanently.
- **No combinational paths:** none from inputs to `out_valid` or `out_frame`; all outputs are registered.

## Configuration
- The macro `DESER_FRAME_CHECK_EN` selects the checksum behaviour.
- **Defined**
  - At capture, out0 must equal (out3 + out2 + out1) mod 2^WIDTH.
  - On mismatch, the frame is not stored, the slot state is unchanged, and no overrun is flagged.
  - `drop_cnt` increments, saturating at 255.
  - Simultaneous failures on both channels add 2, also saturating.
- **Undefined:** every frame is forwarded, and `drop_cnt` is tied to 0.

## Structure
- **Shared package / constants header:**
  - `DESER_FRAME_WORDS` = 4.
  - Slot state encodings SLOT_EMPTY = 1'b0 and SLOT_FULL = 1'b1.
  - Output state encodings OUT_IDLE = 1'b0 and OUT_HOLD = 1'b1.
  - `DROP_CNT_WIDTH` = 8.
- **Sub-module `frame_slot`, instanced twice, contains:**
  - the `done` edge detect;
  - the slot register and full flag;
  - the overrun detect;
  - the optional checksum check.
- **Top level contains:** the arbiter, the output register, `ovf` and `drop_cnt`.

## Test plan
- **Single frame:** reset, then `done0` rises with `frame0` = {8'h01, 8'h02, 8'h03, 8'h06} and `out_ready` = 1. Expect `out_valid` = 1 exactly in cycle n+2 with that frame and `out_chan` = 0, then `out_valid` = 0 next cycle.
- **Simultaneous arrival:** `done0` and `done1` rise in the same cycle with valid frames. Expect channel 0 output first, then channel 1 on the next cycle; a second simultaneous pair must then grant channel 0 first again.
- **Back-pressure and overrun:** with `out_ready` = 0, `done0` rises three times with frames A, B, C. Expect `out_frame` = A held stable and `ovf` = 2'b01. After `out_ready` rises, B follows A and C is never output. Then `clr_ovf` returns `ovf` to 2'b00.
- **Refill on drain:** a channel 1 slot is FULL and `done1` rises in the same cycle the slot is granted. Expect both frames output and `ovf[1]` = 0.
- **Checksum (with `DESER_FRAME_CHECK_EN`):** a frame {8'h10, 8'h20, 8'h30, 8'h00} is dropped, so `drop_cnt` = 1 and no `out_valid`. 300 bad frames saturate `drop_cnt` at 255. Without the macro the same frame is forwarded and `drop_cnt` = 0.
- **Reset mid-operation:** assert `rst_n` = 0 while `out_valid` = 1 and both slots are FULL. On the next edge all outputs are 0 and the slots are EMPTY. A `done0` held high through reset yields one new capture.
